ysyx_exu_muldiv: RTL and testbench

- Iterative RV M-extension multiply/divide unit for the execution stage; handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU. Uses the same prev_valid/ready and valid/next_ready handshake style as the EXU.
- Parametrised in datapath width and multiplier bits-per-cycle. Supports pipeline flush for mispredicted speculation.

---
 rtl/ysyx_exu_muldiv.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_exu_muldiv.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_exu_muldiv.sv
// ysyx_exu_muldiv: iterative RV M-extension multiply/divide unit beside the single-cycle EXU ALU.
// Latency: accept edge to valid_o is BIT_W/MUL_STEP+1 cycles for MUL ops, BIT_W+1 for DIV ops.
// Backpressure: accepts only while idle; the result is held in DONE until next_ready, so one bubble per op.
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   flush                   abort the in-flight op and drop any held result (highest priority)
//   prev_valid / ready_o    op request handshake; op, src1, src2, tag sampled only on accept
//   valid_o / next_ready    result handshake; res_o and tag_o stay stable while valid_o is high
//   busy_o                  unit is not idle
//
// Optional build macro YSYX_MULDIV_FASTPATH_EN: divide-by-zero, signed divide overflow and
// zero multiply operands skip the iterative phase and deliver valid_o 2 cycles after accept.
// Results are identical in both builds; only latency differs.
module ysyx_exu_muldiv #(
  parameter int unsigned BIT_W    = 32,
  parameter int unsigned MUL_STEP = 4,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             prev_valid,
  output logic             ready_o,
  input  logic [2:0]       op,
  input  logic [BIT_W-1:0] src1,
  input  logic [BIT_W-1:0] src2,
  input  logic [TAG_W-1:0] tag,
  output logic             valid_o,
  input  logic             next_ready,
  output logic [BIT_W-1:0] res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W   = $clog2(BIT_W + 1);
  localparam int unsigned MUL_CYC = BIT_W / MUL_STEP;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [2:0]           op_q;
  logic                 s1_q, s2_q;       // operand sign flags (0 for unsigned operands)
  logic                 dz_q, ov_q, mz_q; // divide-by-zero, signed overflow, multiply-by-zero
  logic [BIT_W-1:0]     a_q, b_q;         // |src1|, |src2|
  logic [2*BIT_W-1:0]   prod_q;           // MUL: {acc, multiplier}; DIV: {remainder, dividend/quotient}
  logic [CNT_W-1:0]     cnt_q;
  logic [TAG_W-1:0]     tag_q;
  logic [BIT_W-1:0]     res_q;
  logic [TAG_W-1:0]     tag_out_q;
  logic                 valid_q;
`ifdef YSYX_MULDIV_FASTPATH_EN
  logic                 fast_q;
`endif

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q != S_IDLE);
  assign valid_o = valid_q;
  assign res_o   = res_q;
  assign tag_o   = tag_out_q;

  // ---------------- accept-side operand conditioning ----------------
  logic             sg1, sg2, n1, n2;
  logic [BIT_W-1:0] abs1, abs2;
  logic             in_dz, in_ov, in_mz;

  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin sg1 = 1'b1; sg2 = 1'b1; end
      3'd2:                   begin sg1 = 1'b1; sg2 = 1'b0; end
      default:                begin sg1 = 1'b0; sg2 = 1'b0; end
    endcase
    n1    = sg1 & src1[BIT_W-1];
    n2    = sg2 & src2[BIT_W-1];
    abs1  = n1 ? -src1 : src1;
    abs2  = n2 ? -src2 : src2;
    in_dz = op[2] & (src2 == '0);
    in_ov = op[2] & ~op[0] & (src1 == {1'b1, {(BIT_W-1){1'b0}}}) & (&src2);
    in_mz = ~op[2] & ((src1 == '0) | (src2 == '0));
  end

  // ---------------- multiply step: retire MUL_STEP multiplier bits ----------------
  logic [BIT_W+MUL_STEP-1:0] part, msum;
  logic [2*BIT_W-1:0]        mul_nxt;

  always_comb begin
    part = '0;
    for (int i = 0; i < int'(MUL_STEP); i++) begin
      if (prod_q[i]) part = part + ({{MUL_STEP{1'b0}}, a_q} << i);
    end
    msum    = {{MUL_STEP{1'b0}}, prod_q[2*BIT_W-1:BIT_W]} + part;
    mul_nxt = {msum, prod_q[BIT_W-1:MUL_STEP]};
  end

  // ---------------- restoring divide step: one quotient bit ----------------
  logic [BIT_W:0]     dsh;
  logic [BIT_W-1:0]   ddf, drem;
  logic               dge;
  logic [2*BIT_W-1:0] div_nxt;

  always_comb begin
    dsh     = {prod_q[2*BIT_W-1:BIT_W], prod_q[BIT_W-1]};
    dge     = (dsh >= {1'b0, b_q});
    // When dge holds the difference is below b_q, so the low BIT_W bits are exact.
    ddf     = dsh[BIT_W-1:0] - b_q;
    drem    = dge ? ddf : dsh[BIT_W-1:0];
    div_nxt = {drem, prod_q[BIT_W-2:0], dge};
  end

  // ---------------- sign fix-up and result selection ----------------
  logic [2*BIT_W-1:0] pfix;
  logic [BIT_W-1:0]   mul_res, qfix, rfix, src1_orig, div_res, fix_res;

  always_comb begin
    pfix      = (s1_q ^ s2_q) ? -prod_q : prod_q;
    mul_res   = (op_q[1:0] == 2'd0) ? pfix[BIT_W-1:0] : pfix[2*BIT_W-1:BIT_W];
    // Fast-path entries never ran the multiplier, so a zero operand forces the result.
    if (mz_q) mul_res = '0;
    src1_orig = s1_q ? -a_q : a_q;
    qfix      = (s1_q ^ s2_q) ? -prod_q[BIT_W-1:0] : prod_q[BIT_W-1:0];
    rfix      = s1_q ? -prod_q[2*BIT_W-1:BIT_W] : prod_q[2*BIT_W-1:BIT_W];
    if (dz_q) begin
      qfix = '1;
      rfix = src1_orig;
    end else if (ov_q) begin
      qfix = src1_orig;
      rfix = '0;
    end
    div_res = op_q[1] ? rfix : qfix;
    fix_res = op_q[2] ? div_res : mul_res;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      mz_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      tag_q     <= '0;
      res_q     <= '0;
      tag_out_q <= '0;
      valid_q   <= 1'b0;
`ifdef YSYX_MULDIV_FASTPATH_EN
      fast_q    <= 1'b0;
`endif
    end else if (flush) begin
      // res_q and tag_out_q deliberately keep their last values.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
`ifdef YSYX_MULDIV_FASTPATH_EN
      fast_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (prev_valid) begin
            op_q   <= op;
            s1_q   <= n1;
            s2_q   <= n2;
            dz_q   <= in_dz;
            ov_q   <= in_ov;
            mz_q   <= in_mz;
            a_q    <= abs1;
            b_q    <= abs2;
            tag_q  <= tag;
            prod_q <= {{BIT_W{1'b0}}, (op[2] ? abs1 : abs2)};
            cnt_q  <= op[2] ? CNT_W'(BIT_W - 1) : CNT_W'(MUL_CYC - 1);
            state_q <= op[2] ? S_DIV : S_MUL;
`ifdef YSYX_MULDIV_FASTPATH_EN
            if (in_dz | in_ov | in_mz) begin
              state_q <= S_FIX;
              fast_q  <= 1'b1;
            end
`endif
          end
        end
        S_MUL: begin
          prod_q <= mul_nxt;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_DIV: begin
          prod_q <= div_nxt;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
`ifdef YSYX_MULDIV_FASTPATH_EN
          // Fast entries dwell one extra cycle here for a fixed 2-cycle latency.
          if (fast_q) begin
            fast_q <= 1'b0;
          end else begin
            res_q     <= fix_res;
            tag_out_q <= tag_q;
            valid_q   <= 1'b1;
            state_q   <= S_DONE;
          end
`else
          res_q     <= fix_res;
          tag_out_q <= tag_q;
          valid_q   <= 1'b1;
          state_q   <= S_DONE;
`endif
        end
        S_DONE: begin
          if (next_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_exu_muldiv.sv
// tb_ysyx_exu_muldiv: directed bench for ysyx_exu_muldiv at default parameters.
// A reference model computes results with plain 64-bit arithmetic and tracks the
// expected handshake timing; a per-cycle monitor compares every output against it.
module tb_ysyx_exu_muldiv;

  logic        clk, rst, flush, prev_valid, next_ready;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic [3:0]  tag;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] res_o;
  logic [3:0]  tag_o;

  ysyx_exu_muldiv #(.BIT_W(32), .MUL_STEP(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .prev_valid(prev_valid), .ready_o(ready_o),
    .op(op), .src1(src1), .src2(src2), .tag(tag),
    .valid_o(valid_o), .next_ready(next_ready),
    .res_o(res_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  bit          busy_m, exp_v, acc_ev;
  logic [31:0] held_res;
  logic [3:0]  held_tag;
  int          cyc_n, nvec, nerr;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb_ = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (o[2] && b == 0) ||
              ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
              (!o[2] && (a == 0 || b == 0));
`ifdef YSYX_MULDIV_FASTPATH_EN
    if (special) return 2;
`else
    if (special) return o[2] ? 33 : 9;
`endif
    return o[2] ? 33 : 9;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s cycle %0d: got 0x%08h, want 0x%08h", nm, cyc_n, act, want);
    end
  endtask

  task automatic timeout_fail(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s cycle %0d: bound expired", nm, cyc_n);
  endtask

  // One clock: update the model from the inputs seen before the edge, then
  // compare every DUT output against the model at the following negedge.
  task automatic cyc();
    exp_t e;
    acc_ev = 0;
    if (rst) begin
      sb.delete(); busy_m = 0; exp_v = 0; held_res = '0; held_tag = '0;
    end else if (flush) begin
      sb.delete(); busy_m = 0; exp_v = 0;
    end else if (exp_v && next_ready) begin
      sb.delete(0); busy_m = 0; exp_v = 0;
    end else if (prev_valid && !busy_m) begin
      e.res = ref_res(op, src1, src2);
      e.tag = tag;
      e.acc = cyc_n + 1;
      e.lat = ref_lat(op, src1, src2);
      sb.push_back(e);
      busy_m = 1;
      acc_ev = 1;
    end
    @(negedge clk);
    cyc_n++;
    exp_v = (sb.size() > 0) && ((cyc_n - sb[0].acc) >= sb[0].lat);
    if (exp_v) begin
      held_res = sb[0].res;
      held_tag = sb[0].tag;
    end
    check("valid_o", 32'(valid_o), 32'(exp_v));
    check("ready_o", 32'(ready_o), 32'(!busy_m));
    check("busy_o",  32'(busy_o),  32'(busy_m));
    check("res_o",   res_o, held_res);
    check("tag_o",   32'(tag_o), 32'(held_tag));
  endtask

  task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    int n = 0;
    bit got = 0;
    op = o; src1 = a; src2 = b; tag = t; prev_valid = 1'b1;
    while (!got && n < 50) begin
      cyc();
      got = acc_ev;
      n++;
    end
    if (!got) timeout_fail("accept");
    prev_valid = 1'b0;
    op = 3'($urandom); src1 = $urandom; src2 = $urandom; tag = 4'($urandom);
  endtask

  task automatic finish_op(input logic [31:0] lit, input logic [3:0] ltag, input int hold);
    int n = 0;
    int h = 0;
    next_ready = (hold == 0);
    while (sb.size() > 0 && n < 200) begin
      cyc();
      n++;
      if (exp_v) begin
        h++;
        if (h >= hold) next_ready = 1'b1;
      end
    end
    if (sb.size() > 0) timeout_fail("result");
    check("res_literal", res_o, lit);
    check("tag_literal", 32'(tag_o), 32'(ltag));
    next_ready = 1'b1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input logic [31:0] lit, input int hold);
    start(o, a, b, t);
    finish_op(lit, t, hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; prev_valid = 1'b0; next_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0; tag = '0;
    cyc_n = 0; nvec = 0; nerr = 0;
    busy_m = 0; exp_v = 0; acc_ev = 0; held_res = '0; held_tag = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // multiply family
    issue(3'd0, 32'd7,         32'hFFFF_FFFA, 4'd5,  32'hFFFF_FFD6, 0);
    issue(3'd1, 32'd7,         32'hFFFF_FFFA, 4'd6,  32'hFFFF_FFFF, 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1,  32'hFFFF_FFFE, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2,         4'd2,  32'hFFFF_FFFF, 0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd3,  32'h4000_0000, 0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4,  32'h8000_0000, 0);
    issue(3'd3, 32'h8000_0000, 32'd2,         4'd2,  32'd1,         0);
    issue(3'd0, 32'd0,         32'h1234_5678, 4'd1,  32'd0,         0);

    // divide family
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,         4'd3,  32'hFFFF_FFFD, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,         4'd4,  32'hFFFF_FFFF, 0);
    issue(3'd5, 32'd100,       32'd7,         4'd7,  32'd14,        0);
    issue(3'd7, 32'd100,       32'd7,         4'd8,  32'd2,         0);
    issue(3'd4, 32'd7,         32'hFFFF_FFFE, 4'd15, 32'hFFFF_FFFD, 0);
    issue(3'd6, 32'd7,         32'hFFFF_FFFE, 4'd0,  32'd1,         0);

    // special cases
    issue(3'd5, 32'd5,         32'd0,         4'd9,  32'hFFFF_FFFF, 0);
    issue(3'd6, 32'd5,         32'd0,         4'd10, 32'd5,         0);
    issue(3'd6, 32'hFFFF_FFFB, 32'd0,         4'd13, 32'hFFFF_FFFB, 0);
    issue(3'd4, 32'hFFFF_FFFB, 32'd0,         4'd14, 32'hFFFF_FFFF, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h8000_0000, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'd0,         0);

    // backpressure: result held for 10 cycles with next_ready low
    issue(3'd5, 32'd1000,      32'd10,        4'd6,  32'd100,       10);
    issue(3'd0, 32'd3,         32'd4,         4'd7,  32'd12,        10);

    // flush 10 cycles into a divide, with a competing request in the same cycle
    start(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd3);
    repeat (9) cyc();
    flush = 1'b1; prev_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd4; tag = 4'd9;
    cyc();
    flush = 1'b0; prev_valid = 1'b0;
    repeat (40) cyc();

    // asynchronous reset in the middle of a multiply
    start(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd6);
    repeat (4) cyc();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_res",   res_o,        32'd0);
    check("rst_tag",   32'(tag_o),   32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();
    issue(3'd0, 32'd3, 32'd4, 4'd7, 32'd12, 0);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
